// File: rtl/mips_harvard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_harvard_pkg
// Description : Shared types and constants for the Harvard instruction path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_harvard_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } imem_state_t;

    // Reset vector of the CPU; word 0 of instruction memory lives here.
    localparam logic [31:0] c_base_addr = 32'hBFC0_0000;
    localparam logic [31:0] c_nop       = 32'h0000_0000;

endpackage : mips_harvard_pkg
`default_nettype wire

// File: rtl/instr_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : instr_word_packer
// Description : Packs big-endian program bytes into 32-bit words, zero-padding
//               a short final word.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_take,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic        o_word_write,
    output logic [31:0] o_word
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;

    // The incoming byte lands in the slot given by the count; lower slots are padding.
    always_comb begin
        case (r_byte_cnt)
            2'd0:    o_word = {i_byte, 24'h000000};
            2'd1:    o_word = {r_shift[7:0], i_byte, 16'h0000};
            2'd2:    o_word = {r_shift[15:0], i_byte, 8'h00};
            default: o_word = {r_shift, i_byte};
        endcase
    end

    assign o_word_write = i_take && (i_last || (r_byte_cnt == 2'd3));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'h000000;
        end else if (o_word_write) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'h000000;
        end else if (i_take) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], i_byte};
        end
    end

endmodule : instr_word_packer
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory
// Description : Byte-loaded instruction store that holds the CPU in reset
//               until the program has been streamed in, then serves fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory
    import mips_harvard_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = c_base_addr
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clk_enable,
    input  logic [31:0]                    instr_address,
    output logic [31:0]                    instr_readdata,
    input  logic                           load_valid,
    input  logic [7:0]                     load_byte,
    input  logic                           load_last,
    output logic                           load_ready,
    output logic                           cpu_reset,
    output logic                           program_loaded,
    output logic                           load_error,
    output logic [$clog2(DEPTH_WORDS):0]   words_loaded
);

    localparam int          c_ptr_w    = $clog2(DEPTH_WORDS) + 1;
    localparam int          c_idx_w    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_limit    = 32'(DEPTH_WORDS) * 32'd4;
    localparam logic [c_ptr_w-1:0] c_depth = c_ptr_w'(DEPTH_WORDS);

    imem_state_t          r_state;
    logic [c_ptr_w-1:0]   r_word_ptr;
    logic [DEPTH_WORDS-1:0] r_valid;
    logic [31:0]          r_mem [DEPTH_WORDS];
    logic                 r_cpu_reset;
    logic                 r_program_loaded;
    logic                 r_load_error;

    logic                 w_xfer;
    logic                 w_full;
    logic                 w_take;
    logic                 w_word_write;
    logic [31:0]          w_word;
    logic [c_idx_w-1:0]   w_wr_idx;
    logic [31:0]          w_offset;
    logic [c_idx_w-1:0]   w_rd_idx;
    logic                 w_rd_hit;

    assign load_ready = clk_enable && (r_state == ST_LOAD);
    assign w_xfer     = load_valid && load_ready;
    assign w_full     = (r_word_ptr == c_depth);
    assign w_take     = w_xfer && !w_full && !reset;
    assign w_wr_idx   = r_word_ptr[c_idx_w-1:0];

    instr_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_take       (w_take),
        .i_byte       (load_byte),
        .i_last       (load_last),
        .o_word_write (w_word_write),
        .o_word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_LOAD;
            r_word_ptr       <= '0;
            r_valid          <= '0;
            r_cpu_reset      <= 1'b1;
            r_program_loaded <= 1'b0;
            r_load_error     <= 1'b0;
        end else if (clk_enable) begin
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer && w_full) begin
                        // No room left: the byte is dropped and the loader is locked out.
                        r_state      <= ST_ERROR;
                        r_load_error <= 1'b1;
                    end else if (w_xfer) begin
                        if (w_word_write) begin
                            r_valid[w_wr_idx] <= 1'b1;
                            r_word_ptr        <= r_word_ptr + c_ptr_w'(1);
                        end
                        if (load_last) begin
                            r_state          <= ST_RUN;
                            r_cpu_reset      <= 1'b0;
                            r_program_loaded <= 1'b1;
                        end
                    end
                end
                ST_RUN:   r_state <= ST_RUN;
                ST_ERROR: r_state <= ST_ERROR;
                default: begin
                    r_state      <= ST_ERROR;
                    r_load_error <= 1'b1;
                    r_cpu_reset  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the valid bits alone decide what is readable.
    always_ff @(posedge clk) begin
        if (w_word_write) begin
            r_mem[w_wr_idx] <= w_word;
        end
    end

    assign w_offset = instr_address - BASE_ADDR;
    assign w_rd_idx = w_offset[c_idx_w+1:2];
    assign w_rd_hit = (r_state == ST_RUN) && (instr_address[1:0] == 2'b00) &&
                      (w_offset < c_limit) && r_valid[w_rd_idx];

    assign instr_readdata = w_rd_hit ? r_mem[w_rd_idx] : c_nop;
    assign cpu_reset      = r_cpu_reset;
    assign program_loaded = r_program_loaded;
    assign load_error     = r_load_error;
    assign words_loaded   = r_word_ptr;

endmodule : instruction_memory
`default_nettype wire

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit instruction words stored.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'hBFC00000, the byte address of word 0 (reset vector).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port clk_enable, input, 1: when 0, all internal state SHALL hold.
REQ-006 Port instr_address, input, 32: byte address of the CPU fetch.
REQ-007 Port instr_readdata, output, 32: instruction word returned to the CPU.
REQ-008 Port load_valid, input, 1: loader byte valid.
REQ-009 Port load_byte, input, 8: program byte, big-endian order (first byte goes to bits 31:24).
REQ-010 Port load_last, input, 1: qualifies the final program byte.
REQ-011 Port load_ready, output, 1: block accepts a byte this cycle.
REQ-012 Port cpu_reset, output, 1: holds the CPU in reset until the program is loaded.
REQ-013 Port program_loaded, output, 1: high in RUN state.
REQ-014 Port load_error, output, 1: high in ERROR state.
REQ-015 Port words_loaded, output, $clog2(DEPTH_WORDS)+1: count of words written.

Function
REQ-016 States SHALL be LOAD, RUN and ERROR; the state after reset SHALL be LOAD.
REQ-017 load_ready SHALL equal clk_enable AND (state==LOAD); a byte transfer occurs when load_valid AND load_ready at a rising edge.
REQ-018 Bytes SHALL be packed into a 32-bit shift register using a 2-bit byte counter; the 4th byte SHALL write the word to mem[word_ptr], set valid[word_ptr], increment word_ptr and words_loaded, and clear the byte counter.
REQ-019 A transfer with load_last on byte counts 0-2 SHALL zero-pad the remaining low bytes and write the word in the same cycle.
REQ-020 A transfer with load_last SHALL move the state to RUN on that edge.
REQ-021 A transfer that would write when word_ptr==DEPTH_WORDS SHALL discard the byte and move to ERROR; ERROR SHALL be exited only by reset.
REQ-022 cpu_reset SHALL be high in LOAD and ERROR and low in RUN; it falls on the edge that accepts the load_last byte.
REQ-023 instr_readdata SHALL be combinational: mem[(instr_address-BASE_ADDR)>>2] when state==RUN, instr_address[1:0]==0, the offset is below DEPTH_WORDS*4 and that word's valid bit is set; otherwise 32'h00000000 (NOP).
REQ-024 Offset arithmetic SHALL be 32-bit unsigned; addresses below BASE_ADDR SHALL wrap to large offsets and read 0.
REQ-025 In RUN, load_valid SHALL be ignored and memory SHALL be read-only.

Reset
REQ-026 Reset SHALL set state=LOAD, word_ptr=0, byte counter=0, shift register=0, words_loaded=0 and clear all valid bits; memory data need not be cleared.
REQ-027 Reset output values SHALL be load_ready=clk_enable, cpu_reset=1, program_loaded=0, load_error=0, instr_readdata=0.
REQ-028 Reset asserted mid-load SHALL discard the partial word and all previously loaded words (valid bits cleared).
REQ-029 Reset SHALL take priority over clk_enable=0.

Structure
REQ-030 The state enum, BASE_ADDR default and NOP constant SHALL live in the shared package mips_harvard_pkg.
REQ-031 Byte packing (counter, shift register, pad-on-last) SHALL be one sub-module, instr_word_packer; storage, FSM and read decode remain in instruction_memory.

Verification
REQ-032 Load 0x0F,0xF0,0x00,0x03,0x27,0xE2,0x00,0x00 with last on byte 8 -> read 0xBFC00000=0x0FF00003, 0xBFC00004=0x27E20000, words_loaded=2, cpu_reset falls on the byte-8 edge.
REQ-033 Load 6 bytes 0x24,0x42,0x00,0x01,0x27,0xE2 with last on byte 6 -> 0xBFC00004 reads 0x27E20000, 0xBFC00008 reads 0, program_loaded=1.
REQ-034 After a load, fetch 0x00000000, 0xBFC00002 and BASE_ADDR+DEPTH_WORDS*4 -> all return 0x00000000.
REQ-035 With DEPTH_WORDS=2, send 9 bytes with no last -> load_error=1 on the 9th byte, load_ready=0, cpu_reset=1.
REQ-036 Send 5 bytes, assert reset for 1 cycle, then load 4 bytes 0x00,0x00,0x00,0x08 with last -> words_loaded=1, word 0=0x00000008, word 1 reads 0.
REQ-037 Drop clk_enable to 0 for 3 cycles mid-word with load_valid=1 -> load_ready=0, no byte consumed, packing resumes correctly afterwards.
